// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port interfaces for imem_loader.
// The loader is the slave of the byte stream and the master of the write port.

interface imem_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

interface imem_wr_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (output imem_we, output imem_waddr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_waddr, input  imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: frames sync/length/payload bytes into 32-bit words and writes them.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.

module imem_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  imem_rx_if.slave   rx,
  imem_wr_if.master  wr,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       err
);

  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [31:0]        shift_q, shift_d;
  logic               rx_ready_q, rx_ready_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         xor_q, xor_d;
`endif

  logic               accept_c;
  logic [LEN_W-1:0]   len_rx_c;

  assign accept_c = rx.rx_valid && rx_ready_q;
  assign len_rx_c = {rx.rx_data, len_q[7:0]};

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d    = xor_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept_c && (rx.rx_data == SYNC_BYTE)) begin
          state_d = S_LEN0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          len_d   = '0;
          wcnt_d  = '0;
          bcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end

      S_LEN0: begin
        if (accept_c) begin
          len_d[7:0] = rx.rx_data;
          state_d    = S_LEN1;
        end
      end

      S_LEN1: begin
        if (accept_c) begin
          len_d = len_rx_c;
          if (len_rx_c == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_FIN;
`endif
          end else if (len_rx_c > LEN_W'(DEPTH)) begin
            // Oversized frame: payload is left for IDLE to discard.
            state_d = S_FIN;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
            wcnt_d  = '0;
            bcnt_d  = '0;
          end
        end
      end

      S_DATA: begin
        if (accept_c) begin
          shift_d[{bcnt_q, 3'b000} +: 8] = rx.rx_data;
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ rx.rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            waddr_d = wcnt_q[ADDR_W-1:0];
            wdata_d = shift_d;
          end
        end
      end

      S_WRITE: begin
        wcnt_d = wcnt_q + LEN_W'(1);
        if (wcnt_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_FIN;
`endif
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept_c) begin
          state_d = S_FIN;
          if (rx.rx_data != xor_q) begin
            err_d = 1'b1;
          end
        end
      end
`endif

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs seen during FIN are set on entry so they line up with that cycle.
    if (state_d == S_FIN) begin
      hold_d = 1'b0;
      done_d = ~err_d;
    end

    rx_ready_d = (state_d != S_WRITE) && (state_d != S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign rx.rx_ready   = rx_ready_q;
  assign wr.imem_we    = we_q;
  assign wr.imem_waddr = waddr_q;
  assign wr.imem_wdata = wdata_q;
  assign cpu_hold      = hold_q;
  assign load_done     = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, oversize rejection, full-depth load, mid-frame reset.
// Adds checksum-frame vectors when IMEM_LOADER_CHECKSUM_EN is defined.

module tb_imem_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;

  logic clk;
  logic rst_n;
  logic cpu_hold;
  logic load_done;
  logic err;

  imem_rx_if                 rx_if ();
  imem_wr_if #(.ADDR_W(ADDR_W)) wr_if ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_if.slave),
    .wr        (wr_if.master),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int  we_ready_bad = 0;
  int  hold_falls   = 0;
  logic fall_done   = 1'b0;
  logic prev_hold   = 1'b0;

  // Capture write strobes and cpu_hold falling edges away from the active edge
  always @(negedge clk) begin
    if (wr_if.imem_we) begin
      wa_q.push_back(wr_if.imem_waddr);
      wd_q.push_back(wr_if.imem_wdata);
      if (rx_if.rx_ready) we_ready_bad++;
    end
    if (prev_hold && !cpu_hold) begin
      hold_falls++;
      fall_done = load_done;
    end
    prev_hold = cpu_hold;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    while (!rx_if.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
    end
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic send_raw(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  // Sends a framed load; appends the payload XOR when the checksum feature is built in.
  task automatic send_frame(input logic [7:0] f[$]);
    logic [7:0] x;
    x = 8'h00;
    foreach (f[i]) begin
      send_byte(f[i]);
      if (i >= 3) x = x ^ f[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] f[$];
  int base;
  int bad_idx;

  initial begin
    rst_n          = 1'b0;
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    #1;
    check("rst_rx_ready",  32'(rx_if.rx_ready),   32'd0);
    check("rst_we",        32'(wr_if.imem_we),    32'd0);
    check("rst_waddr",     32'(wr_if.imem_waddr), 32'd0);
    check("rst_wdata",     wr_if.imem_wdata,      32'd0);
    check("rst_status",    {29'd0, cpu_hold, load_done, err}, 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Two-instruction frame
    base = wa_q.size();
    send_raw('{8'hA5, 8'h02, 8'h00, 8'h13});
    check("t1_hold_mid", 32'(cpu_hold), 32'd1);
    f = '{8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    send_raw(f);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h13 ^ 8'h05 ^ 8'h10 ^ 8'h00 ^ 8'h93 ^ 8'h05 ^ 8'h20 ^ 8'h00);
`endif
    idle(4);
    check("t1_nwrites", 32'(wa_q.size() - base), 32'd2);
    if (wa_q.size() >= base + 2) begin
      check("t1_waddr0", 32'(wa_q[base]),   32'd0);
      check("t1_wdata0", wd_q[base],        32'h0010_0513);
      check("t1_waddr1", 32'(wa_q[base+1]), 32'd1);
      check("t1_wdata1", wd_q[base+1],      32'h0020_0593);
    end
    check("t1_status",    {29'd0, cpu_hold, load_done, err}, 32'b010);
    check("t1_hold_fall", 32'(hold_falls), 32'd1);
    check("t1_fall_done", 32'(fall_done),  32'd1);

    // Leading garbage is discarded
    base = wa_q.size();
    send_raw('{8'h00, 8'hFF});
    send_frame('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    idle(4);
    check("t2_nwrites", 32'(wa_q.size() - base), 32'd1);
    if (wa_q.size() >= base + 1) begin
      check("t2_waddr", 32'(wa_q[base]), 32'd0);
      check("t2_wdata", wd_q[base],      32'hDEAD_BEEF);
    end
    check("t2_ready_in_write", 32'(we_ready_bad), 32'd0);

    // Sync value inside payload is data
    base = wa_q.size();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5});
    idle(4);
    check("t2b_nwrites", 32'(wa_q.size() - base), 32'd1);
    if (wa_q.size() >= base + 1) check("t2b_wdata", wd_q[base], 32'hA5A5_A5A5);

    // Oversized length rejected; trailing bytes discarded
    base = wa_q.size();
    send_raw('{8'hA5, 8'h41, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    idle(4);
    check("t3_nwrites", 32'(wa_q.size() - base), 32'd0);
    check("t3_status",  {29'd0, cpu_hold, load_done, err}, 32'b001);
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00});
    idle(4);
    check("t3_recover", {29'd0, cpu_hold, load_done, err}, 32'b010);

    // Zero-length frame
    base = wa_q.size();
    send_frame('{8'hA5, 8'h00, 8'h00});
    idle(4);
    check("t3b_nwrites", 32'(wa_q.size() - base), 32'd0);
    check("t3b_status",  {29'd0, cpu_hold, load_done, err}, 32'b010);

    // Full-depth load: word i holds value i
    base = wa_q.size();
    f = '{8'hA5, 8'h40, 8'h00};
    for (int i = 0; i < 64; i++) begin
      f.push_back(8'(i));
      f.push_back(8'h00);
      f.push_back(8'h00);
      f.push_back(8'h00);
    end
    send_frame(f);
    idle(4);
    check("t4_nwrites", 32'(wa_q.size() - base), 32'd64);
    if (wa_q.size() >= base + 64) begin
      bad_idx = 0;
      for (int i = 0; i < 64; i++)
        if (32'(wa_q[base+i]) != 32'(i) || wd_q[base+i] != 32'(i)) bad_idx++;
      check("t4_all_words", 32'(bad_idx), 32'd0);
      check("t4_last_waddr", 32'(wa_q[base+63]), 32'd63);
      check("t4_last_wdata", wd_q[base+63],      32'h0000_003F);
    end
    check("t4_status", {29'd0, cpu_hold, load_done, err}, 32'b010);

    // Asynchronous reset two bytes into word 1
    base = wa_q.size();
    send_raw('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_status", {29'd0, cpu_hold, load_done, err}, 32'd0);
    check("t5_rst_port",   {30'd0, rx_if.rx_ready, wr_if.imem_we}, 32'd0);
    check("t5_rst_bus",    wr_if.imem_wdata | 32'(wr_if.imem_waddr), 32'd0);
    check("t5_nwrites",    32'(wa_q.size() - base), 32'd1);
    if (wa_q.size() >= base + 1) check("t5_word0", wd_q[base], 32'h3322_1100);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    base = wa_q.size();
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
    idle(4);
    check("t5_nwrites_after", 32'(wa_q.size() - base), 32'd1);
    if (wa_q.size() >= base + 1) begin
      check("t5_waddr_after", 32'(wa_q[base]), 32'd0);
      check("t5_wdata_after", wd_q[base],      32'h1234_5678);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum pass and fail
    base = wa_q.size();
    send_raw('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04});
    idle(4);
    check("t6_pass_nwrites", 32'(wa_q.size() - base), 32'd1);
    check("t6_pass_status",  {29'd0, cpu_hold, load_done, err}, 32'b010);
    base = wa_q.size();
    send_raw('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    idle(4);
    check("t6_fail_nwrites", 32'(wa_q.size() - base), 32'd1);
    if (wa_q.size() >= base + 1) check("t6_fail_wdata", wd_q[base], 32'h0403_0201);
    check("t6_fail_status",  {29'd0, cpu_hold, load_done, err}, 32'b001);
`endif

    check("ready_in_write_total", 32'(we_ready_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
